// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU arbiter slice.
package alu_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned OPW   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of the ALU arbiter, bundled with directional modports.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned OPW   = alu_pkg::OPW
);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ready;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );

    // Requesters, ALU and response consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter: a lone request wins, a tie goes to the requester named by prio.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt = valid;
        if (valid == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
        gnt_id = gnt[1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for the shared ALU: grant, hold operands for one cycle,
// capture the result and return it tagged with the requester id.
module alu_arbiter #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned OPW   = alu_pkg::OPW
) (
    input  logic         clk,
    input  logic         resetn,
    alu_arbiter_if.slave bus
);
    import alu_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             id_q, id_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [1:0]       gnt;
    logic             gnt_id;

    rr_arb2 u_rr_arb2 (
        .valid  ({bus.req1_valid, bus.req0_valid}),
        .prio   (prio_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Next-state and register update
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        prio_d      = prio_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    a_d     = gnt_id ? bus.req1_a  : bus.req0_a;
                    b_d     = gnt_id ? bus.req1_b  : bus.req0_b;
                    op_d    = gnt_id ? bus.req1_op : bus.req0_op;
                    id_d    = gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = bus.alu_out;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // The loser of this round wins the next tie
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    prio_d      = ~id_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            prio_q      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            prio_q      <= prio_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Ready is a decode of the registered state and the arbiter, as required by the handshake
    assign bus.req0_ready = (state_q == IDLE) && gnt[0];
    assign bus.req1_ready = (state_q == IDLE) && gnt[1];

    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = rsp_data_q;

endmodule
